transmisor_serie: RTL
=====================

# transmisor_serie

Serial frame transmitter that converts an 8-bit parallel word into an asynchronous-style frame: one start bit, data bits LSB first, an optional even-parity bit, and one stop bit, on a single output line. It sits on the `clock150kHz` domain beside the existing count/load sequencer and is the sending end of the frame format that sequencer's receive path consumes. It uses the same `inicio`/`listo` handshake style: `inicio` starts a frame, and `listo` is a one-cycle completion pulse.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `CICLOS_BIT`, default 4: clock cycles per transmitted bit; legal range is 1 to 255.
- `clock150kHz`, input, 1 bit: the single system clock; all logic is on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `inicio`, input, 1 bit: frame start request; sampled only in `reposo`.
- `din`, input, `DATA_WIDTH` bits: word to send; latched on the edge that accepts `inicio`.
- `tx`, output, 1 bit: serial line; idles high.
- `ocupado`, output, 1 bit: high from the first start-bit cycle through the `fin` cycle, inclusive.
- `listo`, output, 1 bit: high for exactly one cycle when a frame completes.

## Operation
- States:
  - `reposo`: `tx`=1, `ocupado`=0, `listo`=0.
  - `arranque`: start bit, `tx`=0.
  - `datos`: `tx` = shift-register bit 0; shifts right once per bit period.
  - `paridad`: `tx` = XOR of the latched data (even parity).
  - `parada`: `tx`=1.
  - `fin`: one cycle only; `tx`=1, `listo`=1.
- Transitions:
  - `reposo` → `arranque` on `inicio`=1. The same edge loads `din` into the shift register and the parity register.
  - `arranque` → `datos` after `CICLOS_BIT` cycles.
  - `datos` → `paridad` after `DATA_WIDTH` bit periods. The bit counter counts 0 to `DATA_WIDTH`-1, then clears.
  - `paridad` → `parada` after `CICLOS_BIT` cycles.
  - `parada` → `fin` after `CICLOS_BIT` cycles.
  - `fin` → `reposo` unconditionally.
- Bit timing comes from a divider counting 0 to `CICLOS_BIT`-1. It clears on every state entry and on every bit boundary. The bit-end tick is asserted when the count equals `CICLOS_BIT`-1.
- `inicio` is ignored in every state except `reposo`. Changes on `din` after the accepting edge have no effect on the frame in flight.
- `inicio` held high continuously gives back-to-back frames separated by exactly the `fin` cycle plus the `reposo` accept cycle.
- Reset values: `tx`=1, `ocupado`=0, `listo`=0, state=`reposo`, all counters and the shift register = 0.
- Reset asserted mid-frame forces these values immediately, asynchronously. The aborted frame is not resumed, and `listo` is not pulsed for it.

## Timing
- Edge E0 samples `inicio`=1 in `reposo`. The first cycle with `tx`=0 is the cycle after E0.
- Frame length N = `DATA_WIDTH` + 3 bits with parity compiled in, or `DATA_WIDTH` + 2 without.
- `tx` carries the frame for N×`CICLOS_BIT` cycles after E0.
- `listo`=1 in cycle N×`CICLOS_BIT`+1 after E0, for one cycle only. The earliest next accept edge is the edge following that cycle.
- `CICLOS_BIT`=1 must work: one cycle per bit, with no extra dead cycles inside the frame.
- All outputs are registered. `tx` and `listo` are glitch-free.

## Configuration
- Macro: `TRANSMISOR_PARIDAD_EN`.
  - Defined: the `paridad` state exists, and the frame is start, data, parity, stop.
  - Undefined: the parity register and the `paridad` state are removed, and `datos` goes directly to `parada`. The frame is start, data, stop, with N = `DATA_WIDTH`+2.

## Structure
- A shared package holds:
  - the state encoding localparams (`reposo`, `arranque`, `datos`, `paridad`, `parada`, `fin`);
  - frame constants: start bit level 0, stop/idle level 1, even parity.
- The receive-side sequencer imports the same frame constants.
- One sub-module is natural: `temporizador_bit`, the `CICLOS_BIT` divider. It has a clear input and a `tick` output, and is reusable by the receiver.

## Test plan
- **Nominal frame with parity:** reset, then `din`=8'hA5, `CICLOS_BIT`=4, `inicio` pulse → `tx` bits 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop), each held 4 cycles. `listo` is high only in cycle 45 after the accept edge.
- **Odd number of ones:** `din`=8'h07 → parity bit 1; `ocupado` high for cycles 1 through 45.
- **Parity compiled out:** macro undefined, `din`=8'hA5 → 10-bit frame. `listo` is high in cycle 41.
- **Busy protection:** `inicio` pulsed again at cycle 10 with `din`=8'hFF → the frame still carries 8'hA5, and only one `listo` pulse occurs.
- **Abort:** `reset` asserted in cycle 20 → `tx`=1 and `ocupado`=0 immediately, and no `listo`. A new `inicio` after release sends a complete, correct frame.
- **Back-to-back, single-cycle bits:** `CICLOS_BIT`=1 and `inicio` held high → consecutive frames, each 11 cycles of `tx` followed by `fin` and `reposo`. The start bit of the next frame appears 2 cycles after the previous stop bit ends.

Source files
------------

// File: rtl/transmisor_serie_pkg.sv
// Shared frame definitions for the serial transmitter and the receive-side sequencer.
// State encoding and line levels live here so both ends agree on the frame format.
package transmisor_serie_pkg;

  typedef enum logic [2:0] {
    reposo   = 3'd0,
    arranque = 3'd1,
    datos    = 3'd2,
    paridad  = 3'd3,
    parada   = 3'd4,
    fin      = 3'd5
  } estado_t;

  localparam logic NIVEL_ARRANQUE = 1'b0;
  localparam logic NIVEL_PARADA   = 1'b1;
  localparam logic PARIDAD_PAR    = 1'b1;  // 1 selects even parity

  // Takes the XOR of the data word and returns the parity bit to transmit.
  function automatic logic bit_paridad(input logic xor_datos);
    return PARIDAD_PAR ? xor_datos : ~xor_datos;
  endfunction

endpackage

// File: rtl/transmisor_serie_temporizador_bit.sv
// Bit-period divider: counts 0..CICLOS_BIT-1 and flags the last cycle of each bit.
// Shared with the receiver, so it knows nothing about frame states.
module temporizador_bit #(
  parameter int CICLOS_BIT = 4
) (
  input  logic clock150kHz,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] CUENTA_MAX = 8'(CICLOS_BIT - 1);

  logic [7:0] cuenta;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock150kHz or posedge reset) begin
    if (reset)              cuenta <= '0;
    else if (clear || tick) cuenta <= '0;
    else                    cuenta <= cuenta + 8'd1;
  end

  assign tick = (cuenta == CUENTA_MAX);

endmodule

// File: rtl/transmisor_serie.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define TRANSMISOR_PARIDAD_EN to include the parity bit in the frame.
module transmisor_serie
  import transmisor_serie_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CICLOS_BIT = 4
) (
  input  logic                  clock150kHz,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  tx,
  output logic                  ocupado,
  output logic                  listo
);

  localparam int            BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);

  estado_t               estado, estado_sig;
  logic [DATA_WIDTH-1:0] desplaza, desplaza_sig;
  logic [BW-1:0]         cuenta_bits, cuenta_bits_sig;
  logic                  tx_sig, ocupado_sig, listo_sig;
  logic                  tick, limpiar;
`ifdef TRANSMISOR_PARIDAD_EN
  logic                  paridad_q, paridad_sig;
`endif

  // Divider restarts on every state entry; bit boundaries inside a state wrap on tick.
  assign limpiar = (estado_sig != estado);

  temporizador_bit #(.CICLOS_BIT(CICLOS_BIT)) u_temporizador (
    .clock150kHz (clock150kHz),
    .reset       (reset),
    .clear       (limpiar),
    .tick        (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    estado_sig      = estado;
    desplaza_sig    = desplaza;
    cuenta_bits_sig = cuenta_bits;
`ifdef TRANSMISOR_PARIDAD_EN
    paridad_sig     = paridad_q;
`endif
    case (estado)
      reposo: if (inicio) begin
        estado_sig   = arranque;
        desplaza_sig = din;
`ifdef TRANSMISOR_PARIDAD_EN
        paridad_sig  = bit_paridad(^din);
`endif
      end
      arranque: if (tick) estado_sig = datos;
      datos: if (tick) begin
        desplaza_sig = desplaza >> 1;
        if (cuenta_bits == BIT_MAX) begin
          cuenta_bits_sig = '0;
`ifdef TRANSMISOR_PARIDAD_EN
          estado_sig      = paridad;
`else
          estado_sig      = parada;
`endif
        end else begin
          cuenta_bits_sig = cuenta_bits + BW'(1);
        end
      end
`ifdef TRANSMISOR_PARIDAD_EN
      paridad: if (tick) estado_sig = parada;
`endif
      parada:  if (tick) estado_sig = fin;
      fin:     estado_sig = reposo;
      default: estado_sig = reposo;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    tx_sig = NIVEL_PARADA;
    case (estado_sig)
      arranque: tx_sig = NIVEL_ARRANQUE;
      datos:    tx_sig = desplaza_sig[0];
`ifdef TRANSMISOR_PARIDAD_EN
      paridad:  tx_sig = paridad_sig;
`endif
      default:  tx_sig = NIVEL_PARADA;
    endcase
    ocupado_sig = (estado_sig != reposo);
    listo_sig   = (estado_sig == fin);
  end

  always_ff @(posedge clock150kHz or posedge reset) begin
    if (reset) begin
      estado      <= reposo;
      desplaza    <= '0;
      cuenta_bits <= '0;
      tx          <= NIVEL_PARADA;
      ocupado     <= 1'b0;
      listo       <= 1'b0;
    end else begin
      estado      <= estado_sig;
      desplaza    <= desplaza_sig;
      cuenta_bits <= cuenta_bits_sig;
      tx          <= tx_sig;
      ocupado     <= ocupado_sig;
      listo       <= listo_sig;
    end
  end

`ifdef TRANSMISOR_PARIDAD_EN
  always_ff @(posedge clock150kHz or posedge reset) begin
    if (reset) paridad_q <= 1'b0;
    else       paridad_q <= paridad_sig;
  end
`endif

endmodule
